cb_arbiter_2x1: RTL and testbench
=================================

CB_ARBITER_2X1 -- requirements
Module: cb_arbiter_2x1

Interface
REQ-001 SHALL have parameter MAX_OT, default 2: max outstanding transactions per channel (read, write). Must be a power of 2 and at least 1.
REQ-002 SHALL have port clk  input  1  single core clock; all logic is rising-edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port m0_cb_mosi_i  input  s_cb_mosi_t  requester 0 (instruction fetch).
REQ-005 SHALL have port m0_cb_miso_o  output  s_cb_miso_t  responses/readies to requester 0.
REQ-006 SHALL have port m1_cb_mosi_i  input  s_cb_mosi_t  requester 1 (LSU).
REQ-007 SHALL have port m1_cb_miso_o  output  s_cb_miso_t  responses/readies to requester 1.
REQ-008 SHALL have port s_cb_mosi_o  output  s_cb_mosi_t  to the shared slave bus.
REQ-009 SHALL have port s_cb_miso_i  input  s_cb_miso_t  from the shared slave bus.

Function
REQ-010 SHALL arbitrate read-address and write-address channels independently, each with its own round-robin pointer (last granted ID).
REQ-011 On a tie, SHALL grant the requester not granted last; after reset, last = M0, so M1 wins the first tie.
REQ-012 SHALL lock the grant while granted *_addr_valid is high and slave *_addr_ready is low; no re-arbitration until handshake.
REQ-013 SHALL forward addr/size/valid of the granted requester only; the non-granted requester sees *_addr_ready = 0.
REQ-014 On an address handshake (valid & ready), SHALL release the lock, update the pointer and push the granted ID into that channel's ID FIFO(s) in the same cycle.
REQ-015 SHALL hold s rd_addr_valid = 0 and both requester rd_addr_ready = 0 while the read ID FIFO holds MAX_OT entries.
REQ-016 SHALL apply the REQ-015 hold to the write-address channel when either write FIFO (data or response) is full.
REQ-017 Read responses: s rd_valid SHALL route to the requester at the read FIFO head; the other requester sees rd_valid = 0.
REQ-018 s rd_ready SHALL equal the head requester's rd_ready; rd_data and rd_resp are broadcast to both.
REQ-019 SHALL pop the read FIFO on s rd_valid & rd_ready.
REQ-020 Read FIFO empty: SHALL drive s rd_ready = 1 and discard any response; no requester rd_valid.
REQ-021 Write data: SHALL forward wr_data/wr_strobe/wr_data_valid only from the requester at the write-data FIFO head.
REQ-022 SHALL forward no write data while the write-data FIFO is empty (no bypass); the non-head requester sees wr_data_ready = 0.
REQ-023 SHALL pop the write-data FIFO on s wr_data_valid & wr_data_ready.
REQ-024 Write responses SHALL route by the write-response FIFO head, with rules equivalent to REQ-017..REQ-020 (wr_resp_valid/ready/error); pop on handshake.
REQ-025 A push and a pop in the same cycle on any FIFO SHALL both occur; occupancy is unchanged, including when the FIFO is full.
REQ-026 Address paths SHALL be combinational (zero added latency); only grant locks, pointers and FIFOs are registered.

Reset
REQ-027 rst low SHALL immediately clear all FIFOs, locks and pointers (last = M0).
REQ-028 During reset, all outgoing valids (s *_addr_valid, wr_data_valid, m* rd_valid, wr_resp_valid) SHALL be 0.
REQ-029 During reset, s rd_ready and s wr_resp_ready SHALL be 1.
REQ-030 Reset mid-transaction SHALL abandon in-flight IDs; late slave responses are discarded per REQ-020.

Structure
REQ-031 cb_master_id_t (1 bit) and the MAX_OT default constant SHALL reside in utils_pkg.
REQ-032 SHALL instantiate sub-module cb_id_fifo (parameterised depth, cb_master_id_t entries, full/empty outputs) three times: rd, wr-data, wr-resp.

Verification
REQ-033 M0 and M1 rd_addr_valid in the same cycle after reset, slave ready -> M1 granted cycle 0, M0 cycle 1.
REQ-034 M1 read 0x100 with slave rd_addr_ready low 3 cycles, M0 requesting throughout -> addr stable at 0x100, M0 blocked until the M1 handshake.
REQ-035 Two reads accepted (M0 then M1), third request pending -> third held until the first rd_valid; responses delivered to M0 then M1 in order.
REQ-036 M1 write 0x200, data 0xDEADBEEF, strobe 0xF, sent the cycle after the address -> slave gets data; wr_resp error routed only to M1.
REQ-037 Spurious s rd_valid with the FIFO empty -> s rd_ready = 1 and both requester rd_valid = 0.
REQ-038 rst asserted with two reads outstanding -> FIFOs empty immediately; subsequent responses discarded.

Source files
------------

// File: rtl/utils_pkg.sv
// utils_pkg: shared core-bus types, constants and the round-robin pick helper
//   cb_master_id_t : 1-bit requester ID (CB_M0 = fetch, CB_M1 = LSU)
//   CB_MAX_OT      : default outstanding transactions per channel
//   s_cb_mosi_t    : requester/master -> slave bundle
//   s_cb_miso_t    : slave -> requester/master bundle
package utils_pkg;
  typedef logic cb_master_id_t;
  localparam cb_master_id_t CB_M0 = 1'b0;
  localparam cb_master_id_t CB_M1 = 1'b1;
  localparam int CB_MAX_OT = 2;
  typedef struct packed {
    logic [31:0] rd_addr;
    logic [1:0]  rd_size;
    logic        rd_addr_valid;
    logic        rd_ready;
    logic [31:0] wr_addr;
    logic [1:0]  wr_size;
    logic        wr_addr_valid;
    logic [31:0] wr_data;
    logic [3:0]  wr_strobe;
    logic        wr_data_valid;
    logic        wr_resp_ready;
  } s_cb_mosi_t;
  typedef struct packed {
    logic        rd_addr_ready;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;
    logic        rd_valid;
    logic        wr_addr_ready;
    logic        wr_data_ready;
    logic        wr_resp_valid;
    logic        wr_resp_error;
  } s_cb_miso_t;
  // A tie goes to whoever was not granted last; otherwise the lone requester wins.
  function automatic cb_master_id_t cb_rr_pick(input logic v0, input logic v1, input cb_master_id_t last);
    return (v0 && v1) ? ~last : (v1 ? CB_M1 : CB_M0);
  endfunction
endpackage

// File: rtl/cb_id_fifo.sv
// cb_id_fifo: small FIFO of requester IDs used to route responses in order
//   clk, rst (async, active-low) ; push/push_id write side ; pop read side
//   head : ID at the front (valid only when !empty) ; full, empty : occupancy flags
module cb_id_fifo
  import utils_pkg::*;
#(
  parameter int DEPTH = CB_MAX_OT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  cb_master_id_t push_id,
  input  logic          pop,
  output cb_master_id_t head,
  output logic          full,
  output logic          empty
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  cb_master_id_t mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic do_push, do_pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction
  assign empty   = cnt == '0;
  assign full    = cnt == CW'(DEPTH);
  assign do_pop  = pop & ~empty;
  // A pop frees the slot in the same cycle, so a push at full is accepted alongside it.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      wr_ptr <= do_push ? nxt(wr_ptr) : wr_ptr;
      rd_ptr <= do_pop ? nxt(rd_ptr) : rd_ptr;
      cnt    <= cnt + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= push_id;
endmodule

// File: rtl/cb_arbiter_2x1.sv
// cb_arbiter_2x1: two-requester core-bus arbiter onto one shared slave
//   clk, rst (async, active-low)
//   m0_cb_mosi_i / m0_cb_miso_o : requester 0 (instruction fetch)
//   m1_cb_mosi_i / m1_cb_miso_o : requester 1 (LSU)
//   s_cb_mosi_o / s_cb_miso_i   : shared slave bus
module cb_arbiter_2x1
  import utils_pkg::*;
#(
  parameter int MAX_OT = CB_MAX_OT
) (
  input  logic       clk,
  input  logic       rst,
  input  s_cb_mosi_t m0_cb_mosi_i,
  output s_cb_miso_t m0_cb_miso_o,
  input  s_cb_mosi_t m1_cb_mosi_i,
  output s_cb_miso_t m1_cb_miso_o,
  output s_cb_mosi_t s_cb_mosi_o,
  input  s_cb_miso_t s_cb_miso_i
);
  cb_master_id_t rd_last, wr_last, rd_lock_id, wr_lock_id, rd_gnt, wr_gnt;
  cb_master_id_t rd_head, wd_head, wr_head;
  logic rd_lock, wr_lock, rd_gv, wr_gv, rd_open, wr_open, rd_hs, wr_hs;
  logic rd_full, rd_empty, wd_full, wd_empty, wr_full, wr_empty;
  logic rd_s_ready, wr_s_ready, wd_valid, rd_pop, wd_pop, wr_pop;
  s_cb_mosi_t rd_src, wr_src, wd_src;
  s_cb_miso_t m_miso [2];
  assign rd_gnt = rd_lock ? rd_lock_id : cb_rr_pick(m0_cb_mosi_i.rd_addr_valid, m1_cb_mosi_i.rd_addr_valid, rd_last);
  assign wr_gnt = wr_lock ? wr_lock_id : cb_rr_pick(m0_cb_mosi_i.wr_addr_valid, m1_cb_mosi_i.wr_addr_valid, wr_last);
  assign rd_src = rd_gnt ? m1_cb_mosi_i : m0_cb_mosi_i;
  assign wr_src = wr_gnt ? m1_cb_mosi_i : m0_cb_mosi_i;
  assign wd_src = wd_head ? m1_cb_mosi_i : m0_cb_mosi_i;
  assign rd_gv  = rd_src.rd_addr_valid;
  assign wr_gv  = wr_src.wr_addr_valid;
  // Address channels close during reset and whenever no ID slot is free to route the reply.
  assign rd_open = rst & ~rd_full;
  assign wr_open = rst & ~wd_full & ~wr_full;
  assign rd_hs   = rd_gv & rd_open & s_cb_miso_i.rd_addr_ready;
  assign wr_hs   = wr_gv & wr_open & s_cb_miso_i.wr_addr_ready;
  // With nobody expecting a response, the slave is drained and the beat dropped.
  assign rd_s_ready = rd_empty | (rd_head ? m1_cb_mosi_i.rd_ready : m0_cb_mosi_i.rd_ready);
  assign wr_s_ready = wr_empty | (wr_head ? m1_cb_mosi_i.wr_resp_ready : m0_cb_mosi_i.wr_resp_ready);
  assign wd_valid   = ~wd_empty & wd_src.wr_data_valid;
  assign rd_pop     = ~rd_empty & s_cb_miso_i.rd_valid & rd_s_ready;
  assign wr_pop     = ~wr_empty & s_cb_miso_i.wr_resp_valid & wr_s_ready;
  assign wd_pop     = wd_valid & s_cb_miso_i.wr_data_ready;
  always_comb begin
    s_cb_mosi_o               = '0;
    s_cb_mosi_o.rd_addr       = rd_src.rd_addr;
    s_cb_mosi_o.rd_size       = rd_src.rd_size;
    s_cb_mosi_o.rd_addr_valid = rd_gv & rd_open;
    s_cb_mosi_o.rd_ready      = rd_s_ready;
    s_cb_mosi_o.wr_addr       = wr_src.wr_addr;
    s_cb_mosi_o.wr_size       = wr_src.wr_size;
    s_cb_mosi_o.wr_addr_valid = wr_gv & wr_open;
    s_cb_mosi_o.wr_data       = wd_src.wr_data;
    s_cb_mosi_o.wr_strobe     = wd_src.wr_strobe;
    s_cb_mosi_o.wr_data_valid = wd_valid;
    s_cb_mosi_o.wr_resp_ready = wr_s_ready;
  end
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      m_miso[i]               = '0;
      m_miso[i].rd_addr_ready = rd_open & (rd_gnt == cb_master_id_t'(i)) & s_cb_miso_i.rd_addr_ready;
      m_miso[i].rd_data       = s_cb_miso_i.rd_data;
      m_miso[i].rd_resp       = s_cb_miso_i.rd_resp;
      m_miso[i].rd_valid      = ~rd_empty & (rd_head == cb_master_id_t'(i)) & s_cb_miso_i.rd_valid;
      m_miso[i].wr_addr_ready = wr_open & (wr_gnt == cb_master_id_t'(i)) & s_cb_miso_i.wr_addr_ready;
      m_miso[i].wr_data_ready = ~wd_empty & (wd_head == cb_master_id_t'(i)) & s_cb_miso_i.wr_data_ready;
      m_miso[i].wr_resp_valid = ~wr_empty & (wr_head == cb_master_id_t'(i)) & s_cb_miso_i.wr_resp_valid;
      m_miso[i].wr_resp_error = s_cb_miso_i.wr_resp_error;
    end
  end
  assign m0_cb_miso_o = m_miso[0];
  assign m1_cb_miso_o = m_miso[1];
  // The grant stays with a requester whose address is pending until the slave takes it.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rd_lock    <= 1'b0;
      wr_lock    <= 1'b0;
      rd_lock_id <= CB_M0;
      wr_lock_id <= CB_M0;
      rd_last    <= CB_M0;
      wr_last    <= CB_M0;
    end else begin
      rd_lock    <= rd_gv & ~rd_hs;
      wr_lock    <= wr_gv & ~wr_hs;
      rd_lock_id <= rd_gnt;
      wr_lock_id <= wr_gnt;
      rd_last    <= rd_hs ? rd_gnt : rd_last;
      wr_last    <= wr_hs ? wr_gnt : wr_last;
    end
  cb_id_fifo #(.DEPTH(MAX_OT)) u_rd_fifo (
    .clk(clk), .rst(rst), .push(rd_hs), .push_id(rd_gnt), .pop(rd_pop),
    .head(rd_head), .full(rd_full), .empty(rd_empty)
  );
  cb_id_fifo #(.DEPTH(MAX_OT)) u_wd_fifo (
    .clk(clk), .rst(rst), .push(wr_hs), .push_id(wr_gnt), .pop(wd_pop),
    .head(wd_head), .full(wd_full), .empty(wd_empty)
  );
  cb_id_fifo #(.DEPTH(MAX_OT)) u_wr_fifo (
    .clk(clk), .rst(rst), .push(wr_hs), .push_id(wr_gnt), .pop(wr_pop),
    .head(wr_head), .full(wr_full), .empty(wr_empty)
  );
endmodule

// File: tb/tb_cb_arbiter_2x1.sv
// tb_cb_arbiter_2x1: randomized bench against a queue-based model of the arbiter
module tb_cb_arbiter_2x1;
  import utils_pkg::*;
  localparam int OT = 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  s_cb_mosi_t m0_mosi, m1_mosi, s_mosi;
  s_cb_miso_t m0_miso, m1_miso, s_miso;
  int checks = 0;
  int errors = 0;
  int last [2];
  int hold [2];
  int rdq [$];
  int wdq [$];
  int wrq [$];
  logic pv [2][2];
  logic [31:0] pa [2][2];
  logic [1:0] ps [2][2];
  always #5 clk = ~clk;
  cb_arbiter_2x1 #(.MAX_OT(OT)) dut (
    .clk(clk), .rst(rst),
    .m0_cb_mosi_i(m0_mosi), .m0_cb_miso_o(m0_miso),
    .m1_cb_mosi_i(m1_mosi), .m1_cb_miso_o(m1_miso),
    .s_cb_mosi_o(s_mosi), .s_cb_miso_i(s_miso)
  );
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic clear_model();
    rdq.delete();
    wdq.delete();
    wrq.delete();
    last = '{0, 0};
    hold = '{-1, -1};
    for (int c = 0; c < 2; c++)
      for (int m = 0; m < 2; m++) pv[c][m] = 1'b0;
  endtask
  task automatic step(input bit rst_mid, input bit force_ready);
    int win [2];
    bit ev [2], hs [2], full [2], sr [2];
    bit v0, v1, s_rdr, s_wrr, wdv, rpop, wdpop, wrpop;
    int rh, wdh, wrh;
    logic got_v, got_r;
    logic [33:0] got_a;
    s_cb_mosi_t mm [2];
    for (int c = 0; c < 2; c++)
      for (int m = 0; m < 2; m++)
        if (!pv[c][m] && $urandom_range(2) == 0) begin
          pv[c][m] = 1'b1;
          pa[c][m] = $urandom;
          ps[c][m] = 2'($urandom_range(3));
        end
    for (int m = 0; m < 2; m++) begin
      mm[m] = '0;
      mm[m].rd_addr = pa[0][m];
      mm[m].rd_size = ps[0][m];
      mm[m].rd_addr_valid = pv[0][m];
      mm[m].rd_ready = 1'($urandom_range(1));
      mm[m].wr_addr = pa[1][m];
      mm[m].wr_size = ps[1][m];
      mm[m].wr_addr_valid = pv[1][m];
      mm[m].wr_data = $urandom;
      mm[m].wr_strobe = 4'($urandom_range(15));
      mm[m].wr_data_valid = 1'($urandom_range(1));
      mm[m].wr_resp_ready = 1'($urandom_range(1));
    end
    m0_mosi = mm[0];
    m1_mosi = mm[1];
    s_miso.rd_addr_ready = force_ready ? 1'b1 : 1'($urandom_range(1));
    s_miso.rd_data = $urandom;
    s_miso.rd_resp = 2'($urandom_range(3));
    s_miso.rd_valid = 1'($urandom_range(1));
    s_miso.wr_addr_ready = 1'($urandom_range(1));
    s_miso.wr_data_ready = 1'($urandom_range(1));
    s_miso.wr_resp_valid = 1'($urandom_range(1));
    s_miso.wr_resp_error = 1'($urandom_range(1));
    if (rst_mid) begin
      rst = 1'b0;
      s_miso.rd_valid = 1'b1;
      s_miso.wr_resp_valid = 1'b1;
      #1;
      check("rst_s_rd_ready", s_mosi.rd_ready, 1);
      check("rst_s_wr_resp_ready", s_mosi.wr_resp_ready, 1);
      check("rst_valids", {s_mosi.rd_addr_valid, s_mosi.wr_addr_valid, s_mosi.wr_data_valid,
            m0_miso.rd_valid, m1_miso.rd_valid, m0_miso.wr_resp_valid, m1_miso.wr_resp_valid}, 0);
      clear_model();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      return;
    end
    #1;
    for (int c = 0; c < 2; c++) begin
      v0 = pv[c][0];
      v1 = pv[c][1];
      win[c] = hold[c] >= 0 ? hold[c] : (v0 && v1) ? 1 - last[c] : v1 ? 1 : v0 ? 0 : -1;
      full[c] = c == 0 ? rdq.size() == OT : (wdq.size() == OT || wrq.size() == OT);
      ev[c] = win[c] >= 0 && !full[c];
      sr[c] = c == 0 ? s_miso.rd_addr_ready : s_miso.wr_addr_ready;
      hs[c] = ev[c] && sr[c];
      got_v = c == 0 ? s_mosi.rd_addr_valid : s_mosi.wr_addr_valid;
      got_a = c == 0 ? {s_mosi.rd_addr, s_mosi.rd_size} : {s_mosi.wr_addr, s_mosi.wr_size};
      check($sformatf("addr_valid_ch%0d", c), got_v, ev[c]);
      if (ev[c]) check($sformatf("addr_ch%0d", c), got_a, {pa[c][win[c]], ps[c][win[c]]});
      for (int m = 0; m < 2; m++)
        if (pv[c][m]) begin
          got_r = m == 0 ? (c == 0 ? m0_miso.rd_addr_ready : m0_miso.wr_addr_ready)
                         : (c == 0 ? m1_miso.rd_addr_ready : m1_miso.wr_addr_ready);
          check($sformatf("addr_ready_ch%0d_m%0d", c, m), got_r, ev[c] && win[c] == m && sr[c]);
        end
    end
    if (force_ready) check("tie_grant_m1_then_m0", m1_miso.rd_addr_ready, last[0] == 0 ? 1 : 0);
    rh = rdq.size() > 0 ? rdq[0] : -1;
    s_rdr = rh < 0 ? 1'b1 : mm[rh].rd_ready;
    check("s_rd_ready", s_mosi.rd_ready, s_rdr);
    check("m_rd_valid", {m0_miso.rd_valid, m1_miso.rd_valid},
          {s_miso.rd_valid && rh == 0, s_miso.rd_valid && rh == 1});
    check("rd_bcast", {m0_miso.rd_data, m1_miso.rd_data, m0_miso.rd_resp, m1_miso.rd_resp},
          {s_miso.rd_data, s_miso.rd_data, s_miso.rd_resp, s_miso.rd_resp});
    rpop = rh >= 0 && s_miso.rd_valid && s_rdr;
    wdh = wdq.size() > 0 ? wdq[0] : -1;
    wdv = wdh >= 0 && mm[wdh].wr_data_valid;
    check("s_wr_data_valid", s_mosi.wr_data_valid, wdv);
    if (wdv) check("wr_data", {s_mosi.wr_data, s_mosi.wr_strobe}, {mm[wdh].wr_data, mm[wdh].wr_strobe});
    for (int m = 0; m < 2; m++)
      if (mm[m].wr_data_valid)
        check($sformatf("wr_data_ready_m%0d", m), m == 0 ? m0_miso.wr_data_ready : m1_miso.wr_data_ready,
              wdh == m && s_miso.wr_data_ready);
    wdpop = wdv && s_miso.wr_data_ready;
    wrh = wrq.size() > 0 ? wrq[0] : -1;
    s_wrr = wrh < 0 ? 1'b1 : mm[wrh].wr_resp_ready;
    check("s_wr_resp_ready", s_mosi.wr_resp_ready, s_wrr);
    check("m_wr_resp_valid", {m0_miso.wr_resp_valid, m1_miso.wr_resp_valid},
          {s_miso.wr_resp_valid && wrh == 0, s_miso.wr_resp_valid && wrh == 1});
    check("wr_err_bcast", {m0_miso.wr_resp_error, m1_miso.wr_resp_error}, {2{s_miso.wr_resp_error}});
    wrpop = wrh >= 0 && s_miso.wr_resp_valid && s_wrr;
    @(posedge clk);
    if (rpop) void'(rdq.pop_front());
    if (wdpop) void'(wdq.pop_front());
    if (wrpop) void'(wrq.pop_front());
    for (int c = 0; c < 2; c++) begin
      if (hs[c]) begin
        if (c == 0) rdq.push_back(win[c]);
        else begin
          wdq.push_back(win[c]);
          wrq.push_back(win[c]);
        end
        last[c] = win[c];
        pv[c][win[c]] = 1'b0;
      end
      hold[c] = (win[c] >= 0 && !hs[c]) ? win[c] : -1;
    end
    @(negedge clk);
  endtask
  initial begin
    m0_mosi = '0;
    m1_mosi = '0;
    s_miso = '0;
    clear_model();
    m0_mosi.rd_addr_valid = 1'b1;
    m1_mosi.wr_addr_valid = 1'b1;
    s_miso.rd_valid = 1'b1;
    s_miso.wr_resp_valid = 1'b1;
    #1;
    check("reset_s_ready", {s_mosi.rd_ready, s_mosi.wr_resp_ready}, 2'b11);
    check("reset_valids", {s_mosi.rd_addr_valid, s_mosi.wr_addr_valid, s_mosi.wr_data_valid,
          m0_miso.rd_valid, m1_miso.rd_valid, m0_miso.wr_resp_valid, m1_miso.wr_resp_valid}, 0);
    repeat (2) @(negedge clk);
    m0_mosi = '0;
    m1_mosi = '0;
    s_miso = '0;
    rst = 1'b1;
    pv[0][0] = 1'b1;
    pv[0][1] = 1'b1;
    pa[0][0] = 32'h0000_0040;
    pa[0][1] = 32'h0000_0100;
    ps[0][0] = 2'd2;
    ps[0][1] = 2'd2;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    for (int i = 0; i < 3000; i++) step(i == 1000 || i == 2000, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
